// File: rtl/ifetch_if.sv
// rtl/ifetch_if.sv - fetch-side bus bundle: pipeline control, instruction ROM port and fetched instruction.
// Optional misalign_o exists only when IFETCH_MISALIGN_EN is defined.
`ifndef SYS_SPACE
`define SYS_SPACE 32
`endif
`ifndef INST_WIDTH
`define INST_WIDTH 32
`endif

interface ifetch_if;
  logic                   stall_i;
  logic                   redirect_i;
  logic [`SYS_SPACE-1:0]  redirect_pc_i;
  logic                   rom_re_o;
  logic [`SYS_SPACE-1:0]  rom_addr_o;
  logic [`INST_WIDTH-1:0] rom_inst_i;
  logic                   valid_o;
  logic [`INST_WIDTH-1:0] inst_o;
  logic [`SYS_SPACE-1:0]  pc_o;
`ifdef IFETCH_MISALIGN_EN
  logic                   misalign_o;
`endif

  modport master (
    input  stall_i, redirect_i, redirect_pc_i, rom_inst_i,
    output rom_re_o, rom_addr_o, valid_o, inst_o, pc_o
`ifdef IFETCH_MISALIGN_EN
    , output misalign_o
`endif
  );

  modport slave (
    output stall_i, redirect_i, redirect_pc_i, rom_inst_i,
    input  rom_re_o, rom_addr_o, valid_o, inst_o, pc_o
`ifdef IFETCH_MISALIGN_EN
    , input misalign_o
`endif
  );
endinterface

// File: rtl/ifetch.sv
// rtl/ifetch.sv - instruction fetch stage with stall replay and redirect squash.
// IFETCH_MISALIGN_EN adds a HALT state entered on a misaligned redirect target.
`ifndef SYS_SPACE
`define SYS_SPACE 32
`endif
`ifndef INST_WIDTH
`define INST_WIDTH 32
`endif

module ifetch #(
  parameter logic [`SYS_SPACE-1:0] RESET_PC = '0
) (
  input  logic     clk_i,
  input  logic     rst_n_i,
  ifetch_if.master bus
);
  localparam int AW = `SYS_SPACE;
  localparam int IW = `INST_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   req_pc_q, req_pc_d;
  logic [AW-1:0]   target;
  logic            rom_re;
  logic [AW-1:0]   rom_addr;
  logic            valid;
  logic [IW-1:0]   inst;
  logic [AW-1:0]   pc;
  logic            misalign;

`ifdef IFETCH_MISALIGN_EN
  logic misaligned;
  assign target     = bus.redirect_pc_i;
  assign misaligned = |bus.redirect_pc_i[1:0];
`else
  assign target     = {bus.redirect_pc_i[AW-1:2], 2'b00};
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= S_IDLE;
      req_pc_q <= RESET_PC;
    end else begin
      state_q  <= state_d;
      req_pc_q <= req_pc_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    req_pc_d = req_pc_q;
    rom_re   = 1'b0;
    rom_addr = req_pc_q;
    valid    = 1'b0;
    inst     = '0;
    pc       = req_pc_q;
    misalign = 1'b0;

    case (state_q)
      S_IDLE: begin
        rom_re   = 1'b1;
        rom_addr = RESET_PC;
        req_pc_d = RESET_PC;
        state_d  = S_RUN;
      end
      S_RUN: begin
        rom_re = 1'b1;
        valid  = 1'b1;
        inst   = bus.rom_inst_i;
        // A stall re-reads the same word so the ROM output stays on this instruction.
        if (!bus.stall_i) begin
          req_pc_d = req_pc_q + AW'(4);
        end
        rom_addr = req_pc_d;
      end
      S_HALT: begin
        valid    = 1'b1;
        misalign = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    // Redirect overrides everything: squash the wrong-path word and refetch.
    if (bus.redirect_i) begin
      rom_re   = 1'b1;
      rom_addr = target;
      req_pc_d = target;
      valid    = 1'b0;
      inst     = '0;
      state_d  = S_RUN;
`ifdef IFETCH_MISALIGN_EN
      if (misaligned) state_d = S_HALT;
`endif
    end

    if (!rst_n_i) begin
      rom_re   = 1'b0;
      rom_addr = RESET_PC;
      valid    = 1'b0;
      inst     = '0;
      pc       = RESET_PC;
      misalign = 1'b0;
    end
  end

  assign bus.rom_re_o   = rom_re;
  assign bus.rom_addr_o = rom_addr;
  assign bus.valid_o    = valid;
  assign bus.inst_o     = inst;
  assign bus.pc_o       = pc;
`ifdef IFETCH_MISALIGN_EN
  assign bus.misalign_o = misalign;
`else
  logic unused_misalign;
  assign unused_misalign = misalign;
`endif
endmodule
